io_bus_arbiter: RTL and testbench

- Shares the single device-access port of the IO bus between two requesters: requester 0 is the CPU core and requester 1 is the DMA/boot-loader engine.
- Uses registered round-robin arbitration and holds the grant for one complete transaction.
- Each requester sees the same protocol the bus exposes:
  - an OUT transaction is a valid/bits/ready handshake toward the device;
  - an IN transaction is a ready/valid/bits handshake from the device;
  - both are addressed by a 32-bit dev_id.
- A watchdog aborts transactions to devices that never respond, so a stuck device cannot lock the bus.

---
 rtl/io_bus_arbiter_pkg.sv | 14 +
 rtl/io_bus_watchdog.sv | 38 +++
 rtl/io_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_io_bus_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester IO bus arbiter.
// Imported by the arbiter top and its watchdog.
package io_bus_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int NUM_REQ = 2;

  localparam logic [31:0] ABORT_DATA = 32'hdeadbeef;

endpackage

// File: rtl/io_bus_watchdog.sv
// Saturating stall counter; expired while the count sits at limit-1.
// Shared by the IO bus arbiter and the peripheral stall monitors.
module io_bus_watchdog #(
  parameter int unsigned TimeoutCycles = 65535
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned W = $clog2(TimeoutCycles + 1);
  localparam logic [W-1:0] LIMIT = W'(TimeoutCycles - 1);
  localparam logic [W-1:0] CMAX = '1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && cnt_q != CMAX) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = (cnt_q == LIMIT);

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin owner of the IO bus device port for CPU (0) and DMA (1).
// Grant is held for one transaction; a watchdog aborts stuck devices.
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 65535,
  parameter logic [31:0] AbortData = ABORT_DATA
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_req_dev_id    [NUM_REQ],
  input  logic        i_req_out_valid [NUM_REQ],
  input  logic [31:0] i_req_out_bits  [NUM_REQ],
  output logic        o_req_out_ready [NUM_REQ],
  input  logic        i_req_in_ready  [NUM_REQ],
  output logic        o_req_in_valid  [NUM_REQ],
  output logic [31:0] o_req_in_bits   [NUM_REQ],
  output logic [31:0] o_bus_dev_id,
  output logic        o_bus_out_valid,
  output logic [31:0] o_bus_out_bits,
  input  logic        i_bus_out_ready,
  output logic        o_bus_in_ready,
  input  logic        i_bus_in_valid,
  input  logic [31:0] i_bus_in_bits,
  output logic        o_timeout,
  output logic [1:0]  o_grant
);

  state_e state_q, state_d;
  logic   own_q, own_d;
  logic   last_q, last_d;

  logic [NUM_REQ-1:0] req;
  logic busy, out_leg, in_leg, hs, abort;
  logic expired, wd_clr, wd_en;

  always_comb begin
    for (int n = 0; n < NUM_REQ; n++) begin
      req[n] = i_req_out_valid[n] | i_req_in_ready[n];
    end
  end

  // OUT leg wins when a requester illegally raises both.
  assign busy    = (state_q == BUSY);
  assign out_leg = i_req_out_valid[own_q];
  assign in_leg  = i_req_in_ready[own_q] & ~out_leg;
  assign hs      = busy & ((out_leg & i_bus_out_ready)
                         | (in_leg & i_bus_in_valid));
  assign abort   = busy & req[own_q] & ~hs & expired;
  assign wd_en   = busy & ~hs;
  assign wd_clr  = ~busy | hs | ~req[own_q] | abort;

  io_bus_watchdog #(
    .TimeoutCycles(TimeoutCycles)
  ) u_wdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (wd_clr),
    .i_en      (wd_en),
    .o_expired (expired)
  );

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          own_d   = req[~last_q] ? ~last_q : last_q;
        end
      end
      BUSY: begin
        if (hs | ~req[own_q] | abort) begin
          state_d = IDLE;
          last_d  = own_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    o_grant         = '0;
    o_bus_dev_id    = '0;
    o_bus_out_valid = 1'b0;
    o_bus_out_bits  = '0;
    o_bus_in_ready  = 1'b0;
    o_timeout       = abort;
    for (int n = 0; n < NUM_REQ; n++) begin
      o_req_out_ready[n] = 1'b0;
      o_req_in_valid[n]  = 1'b0;
      o_req_in_bits[n]   = '0;
    end
    if (busy) begin
      o_grant[own_q]         = 1'b1;
      o_bus_dev_id           = i_req_dev_id[own_q];
      o_bus_out_valid        = out_leg & ~abort;
      o_bus_out_bits         = i_req_out_bits[own_q];
      o_bus_in_ready         = in_leg & ~abort;
      o_req_out_ready[own_q] = i_bus_out_ready | (abort & out_leg);
      o_req_in_valid[own_q]  = (~out_leg & i_bus_in_valid)
                             | (abort & in_leg);
      o_req_in_bits[own_q]   = (abort & in_leg) ? AbortData
                                                : i_bus_in_bits;
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter with a cycle-level reference model.
// Model tracks owner, last winner and stalled BUSY cycles as integers.
module tb_io_bus_arbiter;

  localparam int T = 8;
  localparam logic [31:0] ABORT = 32'hdeadbeef;

  logic clk = 1'b0;
  logic i_rst = 1'b0;

  logic [31:0] dev   [2];
  logic        ov    [2];
  logic [31:0] obits [2];
  logic        ordy  [2];
  logic        ir    [2];
  logic        ivld  [2];
  logic [31:0] ibits [2];

  logic [31:0] bus_dev;
  logic        bus_ov;
  logic [31:0] bus_obits;
  logic        bus_ordy;
  logic        bus_ir;
  logic        bus_ivld;
  logic [31:0] bus_ibits;
  logic        tmo;
  logic [1:0]  gnt;

  int n_err = 0;
  int n_chk = 0;

  io_bus_arbiter #(
    .TimeoutCycles(T)
  ) dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_req_dev_id    (dev),
    .i_req_out_valid (ov),
    .i_req_out_bits  (obits),
    .o_req_out_ready (ordy),
    .i_req_in_ready  (ir),
    .o_req_in_valid  (ivld),
    .o_req_in_bits   (ibits),
    .o_bus_dev_id    (bus_dev),
    .o_bus_out_valid (bus_ov),
    .o_bus_out_bits  (bus_obits),
    .i_bus_out_ready (bus_ordy),
    .o_bus_in_ready  (bus_ir),
    .i_bus_in_valid  (bus_ivld),
    .i_bus_in_bits   (bus_ibits),
    .o_timeout       (tmo),
    .o_grant         (gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: owner -1 means idle.
  int m_own = -1, m_last = 1, m_wait = 0;
  int n_own = -1, n_last = 1, n_wait = 0;

  logic [1:0]  e_gnt;
  logic [31:0] e_dev, e_obits;
  logic        e_ov, e_ir, e_to;
  logic        e_ordy [2];
  logic        e_ivld [2];
  logic [31:0] e_ibits [2];
  bit          rq [2];
  bit          hs, ab, oleg, ileg;
  int          g;

  always @(negedge clk) begin
    e_gnt = '0; e_dev = '0; e_obits = '0;
    e_ov = 0; e_ir = 0; e_to = 0;
    for (int n = 0; n < 2; n++) begin
      e_ordy[n] = 0; e_ivld[n] = 0; e_ibits[n] = '0;
      rq[n] = ov[n] || ir[n];
    end
    n_own = m_own; n_last = m_last; n_wait = m_wait;
    if (!i_rst) begin
      n_own = -1; n_last = 1; n_wait = 0;
    end else if (m_own < 0) begin
      if (rq[0] || rq[1])
        n_own = rq[1 - m_last] ? 1 - m_last : m_last;
    end else begin
      g = m_own;
      oleg = ov[g];
      ileg = ir[g] && !ov[g];
      hs = (oleg && bus_ordy) || (ileg && bus_ivld);
      ab = rq[g] && !hs && (m_wait == T - 1);
      e_gnt = 2'(1 << g);
      e_dev = dev[g];
      e_obits = obits[g];
      e_ov = oleg && !ab;
      e_ir = ileg && !ab;
      e_to = ab;
      e_ordy[g] = bus_ordy || (ab && oleg);
      e_ivld[g] = (!oleg && bus_ivld) || (ab && ileg);
      e_ibits[g] = (ab && ileg) ? ABORT : bus_ibits;
      if (hs || !rq[g] || ab) begin
        n_own = -1; n_last = g; n_wait = 0;
      end else begin
        n_wait = m_wait + 1;
      end
    end
    chk("m_grant", 32'(gnt), 32'(e_gnt));
    chk("m_dev", bus_dev, e_dev);
    chk("m_bus_ov", 32'(bus_ov), 32'(e_ov));
    chk("m_bus_obits", bus_obits, e_obits);
    chk("m_bus_ir", 32'(bus_ir), 32'(e_ir));
    chk("m_timeout", 32'(tmo), 32'(e_to));
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("m_ordy%0d", n), 32'(ordy[n]), 32'(e_ordy[n]));
      chk($sformatf("m_ivld%0d", n), 32'(ivld[n]), 32'(e_ivld[n]));
      chk($sformatf("m_ibits%0d", n), ibits[n], e_ibits[n]);
    end
  end

  always @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      m_own <= -1; m_last <= 1; m_wait <= 0;
    end else begin
      m_own <= n_own; m_last <= n_last; m_wait <= n_wait;
    end
  end

  task automatic clear_in();
    for (int n = 0; n < 2; n++) begin
      dev[n] = '0; ov[n] = 0; obits[n] = '0; ir[n] = 0;
    end
    bus_ordy = 0; bus_ivld = 0; bus_ibits = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clear_in();
    i_rst = 0;
    @(posedge clk); #1;
    i_rst = 1;
  endtask

  int cnt, tcnt, n0, n1;
  logic [1:0] gq [$];
  logic [1:0] gexp [8];

  initial begin
    clear_in();
    #2;
    chk("rst_grant", 32'(gnt), 32'h0);
    chk("rst_timeout", 32'(tmo), 32'h0);
    chk("rst_bus_ov", 32'(bus_ov), 32'h0);
    @(posedge clk); #1;
    i_rst = 1;

    // Single OUT write from requester 0.
    do_reset();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      dev[0] = 32'h4; obits[0] = 32'h5a; bus_ordy = 1;
      ov[0] = (i < 2);
      @(negedge clk);
      if (bus_ov && bus_ordy && bus_obits == 32'h5a) cnt++;
      if (i == 0) chk("t1_no_early_valid", 32'(bus_ov), 32'h0);
      if (i == 1) begin
        chk("t1_bus_ov", 32'(bus_ov), 32'h1);
        chk("t1_ordy0", 32'(ordy[0]), 32'h1);
        chk("t1_grant", 32'(gnt), 32'h1);
        chk("t1_dev", bus_dev, 32'h4);
      end
      if (i == 2) chk("t1_grant_idle", 32'(gnt), 32'h0);
    end
    chk("t1_writes", 32'(cnt), 32'h1);

    // Both requesters reading continuously: strict alternation.
    do_reset();
    gq.delete();
    n0 = 0; n1 = 0;
    gexp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      dev[0] = 32'h1002; dev[1] = 32'h1002;
      ir[0] = 1; ir[1] = 1;
      bus_ivld = 1; bus_ibits = 32'd15000000;
      @(negedge clk);
      gq.push_back(gnt);
      if (ivld[0] && ibits[0] == 32'd15000000) n0++;
      if (ivld[1] && ibits[1] == 32'd15000000) n1++;
    end
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_grant%0d", i), 32'(gq[i]), 32'(gexp[i]));
    chk("t2_rx0", 32'(n0), 32'd2);
    chk("t2_rx1", 32'(n1), 32'd2);

    // Requester 1 reads from a silent device: watchdog abort.
    do_reset();
    tcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      ir[1] = 1;
      @(negedge clk);
      if (tmo) tcnt++;
      if (i == 8) begin
        chk("t3_timeout", 32'(tmo), 32'h1);
        chk("t3_ivld1", 32'(ivld[1]), 32'h1);
        chk("t3_ibits1", ibits[1], ABORT);
        chk("t3_bus_ir", 32'(bus_ir), 32'h0);
      end
      if (i == 9) chk("t3_idle", 32'(gnt), 32'h0);
    end
    chk("t3_pulses", 32'(tcnt), 32'h1);

    // Handshake lands on the last allowed BUSY cycle.
    do_reset();
    tcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      ir[0] = (i < 9);
      bus_ivld = (i == 8);
      bus_ibits = 32'h1234;
      @(negedge clk);
      if (tmo) tcnt++;
      if (i == 8) begin
        chk("t4_ivld0", 32'(ivld[0]), 32'h1);
        chk("t4_ibits0", ibits[0], 32'h1234);
      end
      if (i == 9) chk("t4_idle", 32'(gnt), 32'h0);
    end
    chk("t4_no_timeout", 32'(tcnt), 32'h0);

    // Requester 0 withdraws while requester 1 waits.
    do_reset();
    tcnt = 0; cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      ov[0] = (i < 4); obits[0] = 32'h99;
      ir[1] = (i < 7); dev[1] = 32'h20;
      bus_ivld = 1; bus_ibits = 32'h55;
      @(negedge clk);
      if (tmo) tcnt++;
      if (ov[0] && ordy[0]) cnt++;
      if (i == 3) chk("t5_own0", 32'(gnt), 32'h1);
      if (i == 5) chk("t5_idle", 32'(gnt), 32'h0);
      if (i == 6) begin
        chk("t5_own1", 32'(gnt), 32'h2);
        chk("t5_ivld1", 32'(ivld[1]), 32'h1);
      end
    end
    chk("t5_no_timeout", 32'(tcnt), 32'h0);
    chk("t5_no_hs0", 32'(cnt), 32'h0);

    // Asynchronous reset in the middle of a transaction.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      ov[0] = 1; dev[0] = 32'h77;
      @(negedge clk);
    end
    chk("t6_busy", 32'(gnt), 32'h1);
    #2;
    i_rst = 0;
    #1;
    chk("t6_rst_grant", 32'(gnt), 32'h0);
    chk("t6_rst_dev", bus_dev, 32'h0);
    chk("t6_rst_ov", 32'(bus_ov), 32'h0);
    @(posedge clk); #2;
    ov[1] = 1;
    i_rst = 1;
    @(negedge clk);
    chk("t6_idle", 32'(gnt), 32'h0);
    @(negedge clk);
    chk("t6_first_owner", 32'(gnt), 32'h1);
    @(posedge clk); #1;
    clear_in();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
